// File: rtl/capture_dump.sv
// capture_dump: replays the circular capture RAM, oldest sample first, into the UART
module capture_dump #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_start,
    input  logic [2:0]      ch_sel,
    input  logic [LOG2-1:0] waddr_end,
    input  logic [7:0]      rdata,
    input  logic            tx_done,
    output logic            re,
    output logic [LOG2-1:0] raddr,
    output logic [2:0]      ram_sel,
    output logic            trmt,
    output logic [7:0]      tx_data,
    output logic            busy,
    output logic            dump_done,
    output logic            clr_capture_done
);
    typedef enum logic [1:0] {IDLE, RD, LD, WT} state_t;
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    state_t          r_state;
    logic [LOG2-1:0] r_cnt;
    logic [LOG2-1:0] w_raddr_nxt;
    // address walks the ring and wraps at the last real entry, not at 2**LOG2
    assign w_raddr_nxt = (raddr == LAST) ? '0 : raddr + LOG2'(1);
    // dump sequencer: one RAM read, one UART byte, wait for its completion, repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            raddr            <= '0;
            ram_sel          <= '0;
            tx_data          <= '0;
            re               <= 1'b0;
            trmt             <= 1'b0;
            busy             <= 1'b0;
            dump_done        <= 1'b0;
            clr_capture_done <= 1'b0;
        end else begin
            re               <= 1'b0;
            trmt             <= 1'b0;
            dump_done        <= 1'b0;
            clr_capture_done <= 1'b0;
            case (r_state)
                IDLE: if (dump_start) begin
                    raddr   <= (waddr_end > LAST) ? '0 : waddr_end;
                    ram_sel <= ch_sel;
                    r_cnt   <= '0;
                    re      <= 1'b1;
                    busy    <= 1'b1;
                    r_state <= RD;
                end
                RD: r_state <= LD;
                LD: begin
                    tx_data <= rdata;
                    trmt    <= 1'b1;
                    r_state <= WT;
                end
                WT: if (tx_done) begin
                    if (r_cnt == LAST) begin
                        dump_done        <= 1'b1;
                        clr_capture_done <= 1'b1;
                        busy             <= 1'b0;
                        r_state          <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + LOG2'(1);
                        raddr   <= w_raddr_nxt;
                        re      <= 1'b1;
                        r_state <= RD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_dump.sv
// tb_capture_dump: directed checks of the RAM-to-UART dump sequencer at 8 and 384 entries
module tb_capture_dump;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int total = 0;
    int bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask
    // small instance: 8 entries
    logic       ds_a = 1'b0;
    logic [2:0] cs_a = '0;
    logic [3:0] wa_a = '0;
    logic [7:0] rd_a = '0;
    logic       td_a = 1'b0;
    logic       re_a, trmt_a, busy_a, dd_a, clr_a;
    logic [3:0] ra_a;
    logic [2:0] sel_a;
    logic [7:0] txd_a;
    capture_dump #(.ENTRIES(8), .LOG2(4)) u_a (
        .clk(clk), .rst(rst), .dump_start(ds_a), .ch_sel(cs_a), .waddr_end(wa_a),
        .rdata(rd_a), .tx_done(td_a), .re(re_a), .raddr(ra_a), .ram_sel(sel_a),
        .trmt(trmt_a), .tx_data(txd_a), .busy(busy_a), .dump_done(dd_a),
        .clr_capture_done(clr_a)
    );
    // full-size instance: 384 entries
    logic       ds_b = 1'b0;
    logic [2:0] cs_b = '0;
    logic [8:0] wa_b = '0;
    logic [7:0] rd_b = '0;
    logic       td_b = 1'b0;
    logic       re_b, trmt_b, busy_b, dd_b, clr_b;
    logic [8:0] ra_b;
    logic [2:0] sel_b;
    logic [7:0] txd_b;
    capture_dump u_b (
        .clk(clk), .rst(rst), .dump_start(ds_b), .ch_sel(cs_b), .waddr_end(wa_b),
        .rdata(rd_b), .tx_done(td_b), .re(re_b), .raddr(ra_b), .ram_sel(sel_b),
        .trmt(trmt_b), .tx_data(txd_b), .busy(busy_b), .dump_done(dd_b),
        .clr_capture_done(clr_b)
    );
    function automatic logic [7:0] ram_b(input logic [8:0] a);
        return a[7:0] ^ {a[8], 7'b0};
    endfunction
    // RAM models: data valid the cycle after re
    always @(posedge clk) if (re_a) rd_a <= 8'h10 + {4'b0, ra_a};
    always @(posedge clk) if (re_b) rd_b <= ram_b(ra_b);
    // instance A monitor and UART responder (tx_done 5 cycles after trmt)
    logic [7:0] tx_aq[$];
    int done_a = 0;
    int k_a = 0;
    always @(negedge clk) begin
        if (trmt_a) tx_aq.push_back(txd_a);
        if (dd_a || clr_a) begin
            done_a++;
            chk("a_clr_with_done", clr_a, dd_a);
        end
        td_a = 1'b0;
        if (rst) k_a = 0;
        else if (trmt_a) k_a = 5;
        else if (k_a > 0) begin
            k_a--;
            td_a = (k_a == 0);
        end
    end
    // instance B monitor and responder with programmable delay and spurious pulses
    logic [8:0] ra_q[$];
    logic [7:0] tx_q[$];
    int rc_q[$];
    int tc_q[$];
    int dc_q[$];
    int done_b = 0;
    int sel_err = 0;
    int k_b = 0;
    int dly_b = 1;
    logic [2:0] exp_sel = '0;
    logic force_td = 1'b0;
    logic spur = 1'b0;
    logic re_d = 1'b0;
    always @(negedge clk) begin
        if (re_b) begin
            ra_q.push_back(ra_b);
            rc_q.push_back(cyc);
        end
        if (trmt_b) begin
            tx_q.push_back(txd_b);
            tc_q.push_back(cyc);
            if (sel_b !== exp_sel) sel_err++;
        end
        if (dd_b || clr_b) begin
            done_b++;
            chk("b_clr_with_done", clr_b, dd_b);
        end
        td_b = force_td || (spur && (re_b || re_d));
        if (rst) k_b = 0;
        else if (trmt_b) k_b = dly_b;
        else if (k_b > 0) begin
            k_b--;
            if (k_b == 0) begin
                td_b = 1'b1;
                dc_q.push_back(cyc);
            end
        end
        re_d = re_b;
    end
    int br, bt, bd, d0_b, sel0, t_start;
    task automatic start_b(input logic [8:0] wa, input logic [2:0] cs);
        br = ra_q.size();
        bt = tx_q.size();
        bd = dc_q.size();
        d0_b = done_b;
        sel0 = sel_err;
        exp_sel = cs;
        @(negedge clk);
        ds_b = 1'b1;
        wa_b = wa;
        cs_b = cs;
        @(negedge clk);
        ds_b = 1'b0;
        t_start = cyc;
    endtask
    task automatic finish_b(input string tag);
        for (int i = 0; i < 4000 && done_b == d0_b; i++) @(negedge clk);
        chk({tag, "_timeout"}, done_b != d0_b, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_b - d0_b, 1);
        chk({tag, "_busy_after"}, busy_b, 0);
        chk({tag, "_ram_sel"}, sel_err - sel0, 0);
    endtask
    task automatic seq_b(input string tag, input int first);
        int err = 0;
        int e;
        chk({tag, "_nreads"}, ra_q.size() - br, 384);
        chk({tag, "_nbytes"}, tx_q.size() - bt, 384);
        for (int i = 0; i < 384 && br + i < ra_q.size() && bt + i < tx_q.size(); i++) begin
            e = (first + i) % 384;
            if (ra_q[br+i] !== 9'(e)) err++;
            if (tx_q[bt+i] !== ram_b(9'(e))) err++;
        end
        chk({tag, "_sequence"}, err, 0);
        if (ra_q.size() > br) chk({tag, "_first_raddr"}, ra_q[br], first);
    endtask
    logic [7:0] exp_a [8] = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10, 8'h11, 8'h12};
    initial begin
        int d0, err;
        repeat (2) @(negedge clk);
        chk("rst_a_ctl", {busy_a, re_a, trmt_a, dd_a, clr_a}, 0);
        chk("rst_b_ctl", {busy_b, re_b, trmt_b, dd_b, clr_b}, 0);
        chk("rst_b_data", {ra_b, sel_b, txd_b}, 0);
        rst = 1'b0;
        // 8-entry dump from the middle of the ring
        @(negedge clk);
        ds_a = 1'b1;
        wa_a = 4'd3;
        cs_a = 3'd1;
        @(negedge clk);
        ds_a = 1'b0;
        d0 = done_a;
        for (int i = 0; i < 500 && done_a == d0; i++) @(negedge clk);
        chk("a_timeout", done_a != d0, 1);
        repeat (3) @(negedge clk);
        chk("a_nbytes", tx_aq.size(), 8);
        err = 0;
        for (int i = 0; i < 8 && i < tx_aq.size(); i++) if (tx_aq[i] !== exp_a[i]) err++;
        chk("a_bytes", err, 0);
        chk("a_done_pulses", done_a - d0, 1);
        chk("a_busy_after", busy_a, 0);
        chk("a_ram_sel", sel_a, 1);
        // 384-entry dump starting at the last entry, immediate responder, latency
        dly_b = 1;
        start_b(9'd383, 3'd1);
        finish_b("b1");
        seq_b("b1", 383);
        if (ra_q.size() > br + 383) chk("b1_last_raddr", ra_q[br+383], 382);
        if (rc_q.size() > br + 1 && tc_q.size() > bt + 1 && dc_q.size() > bd) begin
            chk("b1_re_lat", rc_q[br] - t_start, 0);
            chk("b1_trmt_lat", tc_q[bt] - rc_q[br], 2);
            chk("b1_re_after_done", rc_q[br+1] - dc_q[bd], 1);
            chk("b1_trmt_after_done", tc_q[bt+1] - dc_q[bd], 3);
        end else chk("b1_timing_events", 0, 1);
        // a second start mid-dump with different ch_sel/waddr_end is ignored
        start_b(9'd5, 3'd2);
        repeat (20) @(negedge clk);
        ds_b = 1'b1;
        cs_b = 3'd4;
        wa_b = 9'd100;
        @(negedge clk);
        ds_b = 1'b0;
        chk("b2_sel_held", sel_b, 2);
        finish_b("b2");
        seq_b("b2", 5);
        // reset during the 100th byte's wait
        dly_b = 5;
        start_b(9'd10, 3'd3);
        for (int i = 0; i < 5000 && tx_q.size() - bt < 100; i++) @(negedge clk);
        chk("b3_reached_100", tx_q.size() - bt >= 100, 1);
        chk("b3_busy_before", busy_b, 1);
        #2 rst = 1'b1;
        #1;
        chk("b3_rst_ctl", {busy_b, re_b, trmt_b, dd_b, clr_b}, 0);
        chk("b3_rst_raddr", ra_b, 0);
        chk("b3_rst_data", {sel_b, txd_b}, 0);
        d0 = done_b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("b3_no_done", done_b - d0, 0);
        dly_b = 1;
        start_b(9'd7, 3'd3);
        finish_b("b3");
        seq_b("b3", 7);
        // spurious tx_done in IDLE, then an out-of-range waddr_end with spurious RD/LD pulses
        force_td = 1'b1;
        repeat (3) @(negedge clk);
        force_td = 1'b0;
        @(negedge clk);
        chk("b4_idle_raddr", ra_b, 6);
        chk("b4_idle_busy", {busy_b, re_b, trmt_b}, 0);
        spur = 1'b1;
        start_b(9'd400, 3'd0);
        finish_b("b4");
        seq_b("b4", 0);
        spur = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/capture_dump.md
Name: capture_dump

Overview:
- Read-side counterpart of the capture unit.
- Once a capture has completed, it reads the circular sample RAM starting at the oldest sample (the capture write pointer at completion), wrapping through all ENTRIES locations.
- Each byte is sent to the UART transmitter with a trmt/tx_done handshake.
- When the final byte is acknowledged, it pulses dump_done and clears the capture_done bit in cmd_cfg, re-enabling capture.

Parameters:
- ENTRIES, 384, number of RAM locations (12288 for DE-0 build).
- LOG2, 9, address width; ENTRIES <= 2**LOG2.

Ports:
- clk  input  1  system clock, all flops posedge.
- rst  input  1  asynchronous active-high reset.
- dump_start  input  1  one-cycle pulse from cmd_cfg requesting a dump.
- ch_sel  input  3  RAM/channel to dump (0-4), sampled on an accepted dump_start.
- waddr_end  input  LOG2  capture write pointer (oldest sample), sampled on an accepted dump_start.
- rdata  input  8  RAM read data, valid the cycle after re is high.
- tx_done  input  1  UART has finished the current byte (one-cycle pulse).
- re  output  1  RAM read enable.
- raddr  output  LOG2  RAM read address.
- ram_sel  output  3  latched ch_sel, drives the RAM read mux.
- trmt  output  1  one-cycle pulse to start a UART transmission.
- tx_data  output  8  byte to transmit; held stable from trmt until tx_done.
- busy  output  1  high in any state other than IDLE.
- dump_done  output  1  one-cycle pulse when the dump completes.
- clr_capture_done  output  1  one-cycle pulse, coincident with dump_done.

Behaviour:
- Reset values: state=IDLE, raddr=0, cnt=0, ram_sel=0, tx_data=0. re, trmt, busy, dump_done and clr_capture_done are all 0.
- States and transitions:
  - IDLE: on dump_start, latch raddr=waddr_end (waddr_end >= ENTRIES latches 0), latch ram_sel=ch_sel, clear cnt, go to RD.
  - RD: re=1 for exactly this cycle; go to LD.
  - LD: tx_data<=rdata; trmt<=1 (registered, so high the next cycle for one cycle only); go to WT.
  - WT: wait for tx_done. On tx_done:
    - if cnt==ENTRIES-1: pulse dump_done and clr_capture_done (registered, one cycle), go to IDLE;
    - else cnt<=cnt+1, raddr<=(raddr==ENTRIES-1)?0:raddr+1, go to RD.
- Latency: dump_start accepted at edge N gives re high in cycle N+1 and trmt high in cycle N+3. After tx_done, the next trmt follows 3 cycles later.
- Byte count: exactly ENTRIES bytes per dump, in order waddr_end, waddr_end+1, ..., ENTRIES-1, 0, ..., waddr_end-1.
- Counter widths:
  - cnt is LOG2 bits; compare against ENTRIES-1 only, never rely on natural overflow.
  - raddr wraps at ENTRIES-1, not at 2**LOG2-1.
- Ignored inputs:
  - dump_start while busy is ignored; ch_sel and waddr_end are not resampled.
  - tx_done outside WT is ignored.
  - tx_done in the same cycle as trmt is not possible per the UART contract, and is treated as a normal tx_done if it occurs in WT.
- Reset mid-dump: immediate return to IDLE with all outputs at reset values, no dump_done and no clr_capture_done. A new dump_start afterwards starts from a fresh waddr_end.
- dump_start in the same cycle as the dump_done pulse (state already IDLE next cycle) is accepted on the following edge only if still asserted then; single-cycle pulses coincident with dump_done are dropped.
- tx_data holds its last value in IDLE.
- re is never asserted outside RD; raddr only changes on an accepted start or a tx_done in WT.

Test Plan:
- ENTRIES=8, waddr_end=3, RAM[i]=0x10+i, tx_done returned 5 cycles after each trmt -> trmt bytes 0x13,0x14,0x15,0x16,0x17,0x10,0x11,0x12. Exactly 8 trmt pulses, then dump_done=clr_capture_done=1 for one cycle and busy=0.
- Default ENTRIES=384, waddr_end=383 -> first raddr=383, second raddr=0, last raddr=382. Exactly 384 bytes sent; cnt never exceeds 383.
- dump_start at edge N with immediate tx_done responder -> re at N+1, trmt at N+3. Next re exactly 1 cycle after tx_done, next trmt 3 cycles after tx_done.
- dump_start pulsed again mid-dump with ch_sel changed 2->4 -> ram_sel stays 2, byte sequence unaffected, single dump_done at end.
- Assert rst during the 100th byte's WT -> all outputs 0 asynchronously, no dump_done. A new dump_start with waddr_end=7 then starts at raddr=7.
- waddr_end=400 with ENTRIES=384 -> dump starts at raddr=0; spurious tx_done pulses in IDLE/RD/LD cause no address or count change.
